// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX hazard inputs, fetch status,
// stage control enables and debug/performance outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  branch_taken;
  logic                  imem_ready;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic [1:0]            ctrl_state;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_count;

  // Pipeline datapath side
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           branch_taken, imem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, ctrl_state,
           stall_cycles, flush_count
  );

  // Hazard controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           branch_taken, imem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, ctrl_state,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central 5-stage pipeline controller: load-use stalls, branch flushes,
// instruction-fetch wait states and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_WAIT = 2'd1,
    IM_WAIT = 2'd2
  } state_e;

  localparam logic [3:0]       LU_RELOAD = 4'(LOAD_LATENCY - 1);
  localparam bit               LU_MULTI  = (LOAD_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_r;
  state_e           state_nxt_s;
  logic [3:0]       wait_cnt_r;
  logic [3:0]       wait_cnt_nxt_s;
  logic             lu_hazard_s;
  logic             pc_write_s;
  logic             ifid_write_s;
  logic             ifid_flush_s;
  logic             idex_bubble_s;
  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] flush_count_r;

  // Load in EX writing a register the ID instruction reads (r0 never hazards)
  always_comb begin
    lu_hazard_s = bus.ex_mem_read
                & (bus.ex_rd != {REG_ADDR_W{1'b0}})
                & ((bus.id_uses_rs & (bus.id_rs == bus.ex_rd))
                 | (bus.id_uses_rt & (bus.id_rt == bus.ex_rd)));
  end

  // Next-state and stage-control decode, priority reset > branch > stall > fetch wait
  always_comb begin
    pc_write_s     = 1'b1;
    ifid_write_s   = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_bubble_s  = 1'b0;
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    if (reset) begin
      pc_write_s     = 1'b0;
      ifid_write_s   = 1'b0;
      ifid_flush_s   = 1'b1;
      idex_bubble_s  = 1'b1;
      state_nxt_s    = RUN;
      wait_cnt_nxt_s = 4'd0;
    end else if (bus.branch_taken) begin
      // ID holds a wrong-path instruction, so any pending load-use stall is moot
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      state_nxt_s   = bus.imem_ready ? RUN : IM_WAIT;
    end else begin
      case (state_r)
        LU_WAIT: begin
          pc_write_s     = 1'b0;
          ifid_write_s   = 1'b0;
          idex_bubble_s  = 1'b1;
          wait_cnt_nxt_s = wait_cnt_r - 4'd1;
          if (wait_cnt_r <= 4'd1) begin
            state_nxt_s = bus.imem_ready ? RUN : IM_WAIT;
          end else begin
            state_nxt_s = LU_WAIT;
          end
        end
        RUN, IM_WAIT: begin
          if (lu_hazard_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
            if (LU_MULTI) begin
              wait_cnt_nxt_s = LU_RELOAD;
              state_nxt_s    = LU_WAIT;
            end else begin
              state_nxt_s = RUN;
            end
          end else if (!bus.imem_ready) begin
            // Feed a NOP into ID while the instruction already there moves on
            pc_write_s   = 1'b0;
            ifid_flush_s = 1'b1;
            state_nxt_s  = IM_WAIT;
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // State and load-latency wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= RUN;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_r <= {CNT_W{1'b0}};
      flush_count_r  <= {CNT_W{1'b0}};
    end else begin
      if (!pc_write_s && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (bus.branch_taken && (flush_count_r != CNT_MAX)) begin
        flush_count_r <= flush_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.pc_write     = pc_write_s;
  assign bus.ifid_write   = ifid_write_s;
  assign bus.ifid_flush   = ifid_flush_s;
  assign bus.idex_bubble  = idex_bubble_s;
  assign bus.ctrl_state   = state_r;
  assign bus.stall_cycles = stall_cycles_r;
  assign bus.flush_count  = flush_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (latency 1/3/4, one with 4-bit
// counters) share stimulus; a stall-budget reference model predicts all outputs.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_mem_read, branch_taken, imem_ready;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus_a ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus_b ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  bus_c ();

  assign bus_a.id_rs = id_rs;        assign bus_b.id_rs = id_rs;        assign bus_c.id_rs = id_rs;
  assign bus_a.id_rt = id_rt;        assign bus_b.id_rt = id_rt;        assign bus_c.id_rt = id_rt;
  assign bus_a.id_uses_rs = id_uses_rs; assign bus_b.id_uses_rs = id_uses_rs; assign bus_c.id_uses_rs = id_uses_rs;
  assign bus_a.id_uses_rt = id_uses_rt; assign bus_b.id_uses_rt = id_uses_rt; assign bus_c.id_uses_rt = id_uses_rt;
  assign bus_a.ex_mem_read = ex_mem_read; assign bus_b.ex_mem_read = ex_mem_read; assign bus_c.ex_mem_read = ex_mem_read;
  assign bus_a.ex_rd = ex_rd;        assign bus_b.ex_rd = ex_rd;        assign bus_c.ex_rd = ex_rd;
  assign bus_a.branch_taken = branch_taken; assign bus_b.branch_taken = branch_taken; assign bus_c.branch_taken = branch_taken;
  assign bus_a.imem_ready = imem_ready; assign bus_b.imem_ready = imem_ready; assign bus_c.imem_ready = imem_ready;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .CNT_W(16)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(4), .CNT_W(4))  dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  // Reference model: remaining stall cycles, pending fetch wait, counter values
  typedef struct {
    int rem;
    bit fw;
    int stall;
    int flush;
  } mdl_t;

  mdl_t mdl [3];

  function automatic int ll_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic int cmax_of(int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  function automatic bit lu_now();
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  function automatic logic [3:0] exp_ctl(mdl_t m);
    if (reset) return 4'b0011;
    if (branch_taken) return 4'b1111;
    if ((m.rem > 0) || lu_now()) return 4'b0001;
    if (!imem_ready) return 4'b0110;
    return 4'b1100;
  endfunction

  function automatic logic [1:0] exp_state(mdl_t m);
    if (m.rem > 0) return 2'd1;
    return m.fw ? 2'd2 : 2'd0;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int ll, int cmax);
    mdl_t       n = m;
    logic [3:0] c = exp_ctl(m);
    if (reset) begin
      n.rem = 0; n.fw = 1'b0; n.stall = 0; n.flush = 0;
    end else begin
      if (!c[3] && (m.stall < cmax)) n.stall = m.stall + 1;
      if (branch_taken) begin
        if (m.flush < cmax) n.flush = m.flush + 1;
        n.rem = 0;
        n.fw  = !imem_ready;
      end else if (m.rem > 0) begin
        n.rem = m.rem - 1;
        if (n.rem == 0) n.fw = !imem_ready;
      end else if (lu_now()) begin
        n.rem = ll - 1;
        n.fw  = 1'b0;
      end else begin
        n.fw = !imem_ready;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) mdl[i] <= mdl_next(mdl[i], ll_of(i), cmax_of(i));
  end

  function automatic logic [3:0] obs_ctl(int i);
    case (i)
      0: return {bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush, bus_a.idex_bubble};
      1: return {bus_b.pc_write, bus_b.ifid_write, bus_b.ifid_flush, bus_b.idex_bubble};
      default: return {bus_c.pc_write, bus_c.ifid_write, bus_c.ifid_flush, bus_c.idex_bubble};
    endcase
  endfunction

  function automatic logic [1:0] obs_state(int i);
    case (i)
      0: return bus_a.ctrl_state;
      1: return bus_b.ctrl_state;
      default: return bus_c.ctrl_state;
    endcase
  endfunction

  function automatic int obs_stall(int i);
    case (i)
      0: return 32'(bus_a.stall_cycles);
      1: return 32'(bus_b.stall_cycles);
      default: return 32'(bus_c.stall_cycles);
    endcase
  endfunction

  function automatic int obs_flush(int i);
    case (i)
      0: return 32'(bus_a.flush_count);
      1: return 32'(bus_b.flush_count);
      default: return 32'(bus_c.flush_count);
    endcase
  endfunction

  task automatic set_idle();
    reset = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1; ex_mem_read = 1'b0;
    ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
  endtask

  task automatic set_hazard_rs5();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1; branch_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks += 4;
      if (obs_ctl(0) !== 4'b0011) begin errors++; $display("FAIL reset_ctl cyc%0d: got %b expected 0011", k, obs_ctl(0)); end
      if (obs_state(0) !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", obs_state(0)); end
      if (obs_stall(2) !== 0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", obs_stall(2)); end
      if (obs_flush(0) !== 0) begin errors++; $display("FAIL reset_flush: got %0d expected 0", obs_flush(0)); end
      @(negedge clk);
    end
    set_idle();
    #1;
    checks += 1;
    if (obs_ctl(0) !== 4'b1100) begin errors++; $display("FAIL reset_release_ctl: got %b expected 1100", obs_ctl(0)); end
    @(negedge clk);
  endtask

  task automatic test_load_use_ll1();
    do_reset();
    set_hazard_rs5();
    #1;
    checks += 1;
    if (obs_ctl(0) !== 4'b0001) begin errors++; $display("FAIL ll1_stall_ctl: got %b expected 0001", obs_ctl(0)); end
    @(negedge clk);
    ex_mem_read = 1'b0;
    #1;
    checks += 3;
    if (obs_ctl(0) !== 4'b1100) begin errors++; $display("FAIL ll1_resume_ctl: got %b expected 1100", obs_ctl(0)); end
    if (obs_state(0) !== 2'd0) begin errors++; $display("FAIL ll1_state: got %0d expected 0", obs_state(0)); end
    if (obs_stall(0) !== 1) begin errors++; $display("FAIL ll1_stall_cnt: got %0d expected 1", obs_stall(0)); end
    @(negedge clk);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    checks += 1;
    if (obs_ctl(0) !== 4'b1100) begin errors++; $display("FAIL ll1_r0_no_stall: got %b expected 1100", obs_ctl(0)); end
    @(negedge clk);
    id_uses_rs = 1'b0; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
    #1;
    checks += 1;
    if (obs_ctl(0) !== 4'b1100) begin errors++; $display("FAIL ll1_rt_unused: got %b expected 1100", obs_ctl(0)); end
    id_uses_rt = 1'b1;
    #1;
    checks += 1;
    if (obs_ctl(0) !== 4'b0001) begin errors++; $display("FAIL ll1_rt_stall: got %b expected 0001", obs_ctl(0)); end
    @(negedge clk);
    set_idle();
    #1;
    checks += 1;
    if (obs_stall(0) !== 2) begin errors++; $display("FAIL ll1_stall_total: got %0d expected 2", obs_stall(0)); end
    @(negedge clk);
  endtask

  task automatic test_load_use_ll3();
    do_reset();
    set_hazard_rs5();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks += 2;
      if (obs_ctl(1) !== 4'b0001) begin errors++; $display("FAIL ll3_stall_ctl cyc%0d: got %b expected 0001", k, obs_ctl(1)); end
      if (obs_state(1) !== ((k == 0) ? 2'd0 : 2'd1)) begin errors++; $display("FAIL ll3_state cyc%0d: got %0d expected %0d", k, obs_state(1), (k == 0) ? 0 : 1); end
      @(negedge clk);
      ex_mem_read = 1'b0;
    end
    #1;
    checks += 3;
    if (obs_ctl(1) !== 4'b1100) begin errors++; $display("FAIL ll3_resume_ctl: got %b expected 1100", obs_ctl(1)); end
    if (obs_state(1) !== 2'd0) begin errors++; $display("FAIL ll3_resume_state: got %0d expected 0", obs_state(1)); end
    if (obs_stall(1) !== 3) begin errors++; $display("FAIL ll3_stall_cnt: got %0d expected 3", obs_stall(1)); end
    @(negedge clk);
  endtask

  task automatic test_branch();
    do_reset();
    set_hazard_rs5();
    branch_taken = 1'b1;
    #1;
    checks += 1;
    if (obs_ctl(1) !== 4'b1111) begin errors++; $display("FAIL br_vs_lu_ctl: got %b expected 1111", obs_ctl(1)); end
    @(negedge clk);
    set_idle();
    #1;
    checks += 3;
    if (obs_state(1) !== 2'd0) begin errors++; $display("FAIL br_vs_lu_state: got %0d expected 0", obs_state(1)); end
    if (obs_flush(1) !== 1) begin errors++; $display("FAIL br_flush_cnt: got %0d expected 1", obs_flush(1)); end
    if (obs_ctl(1) !== 4'b1100) begin errors++; $display("FAIL br_after_ctl: got %b expected 1100", obs_ctl(1)); end
    @(negedge clk);
    do_reset();
    set_hazard_rs5();
    @(negedge clk);
    ex_mem_read = 1'b0; branch_taken = 1'b1;
    #1;
    checks += 2;
    if (obs_state(2) !== 2'd1) begin errors++; $display("FAIL br_mid_luwait_state: got %0d expected 1", obs_state(2)); end
    if (obs_ctl(2) !== 4'b1111) begin errors++; $display("FAIL br_mid_luwait_ctl: got %b expected 1111", obs_ctl(2)); end
    @(negedge clk);
    set_idle();
    #1;
    checks += 4;
    if (obs_state(2) !== 2'd0) begin errors++; $display("FAIL br_abort_state: got %0d expected 0", obs_state(2)); end
    if (obs_ctl(2) !== 4'b1100) begin errors++; $display("FAIL br_abort_ctl: got %b expected 1100", obs_ctl(2)); end
    if (obs_flush(2) !== 1) begin errors++; $display("FAIL br_abort_flush: got %0d expected 1", obs_flush(2)); end
    if (obs_stall(2) !== 1) begin errors++; $display("FAIL br_abort_stall: got %0d expected 1", obs_stall(2)); end
    @(negedge clk);
  endtask

  task automatic test_imem_wait();
    do_reset();
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks += 2;
      if (obs_ctl(0) !== 4'b0110) begin errors++; $display("FAIL imw_ctl cyc%0d: got %b expected 0110", k, obs_ctl(0)); end
      if (obs_state(0) !== ((k == 0) ? 2'd0 : 2'd2)) begin errors++; $display("FAIL imw_state cyc%0d: got %0d expected %0d", k, obs_state(0), (k == 0) ? 0 : 2); end
      @(negedge clk);
    end
    imem_ready = 1'b1;
    #1;
    checks += 3;
    if (obs_ctl(0) !== 4'b1100) begin errors++; $display("FAIL imw_resume_ctl: got %b expected 1100", obs_ctl(0)); end
    if (obs_state(0) !== 2'd2) begin errors++; $display("FAIL imw_resume_state: got %0d expected 2", obs_state(0)); end
    if (obs_stall(0) !== 4) begin errors++; $display("FAIL imw_stall_cnt: got %0d expected 4", obs_stall(0)); end
    @(negedge clk);
    #1;
    checks += 1;
    if (obs_state(0) !== 2'd0) begin errors++; $display("FAIL imw_back_run: got %0d expected 0", obs_state(0)); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 1'b0;
    repeat (20) @(negedge clk);
    imem_ready = 1'b1;
    #1;
    checks += 2;
    if (obs_stall(2) !== 15) begin errors++; $display("FAIL sat_stall_cnt4: got %0d expected 15", obs_stall(2)); end
    if (obs_stall(0) !== 20) begin errors++; $display("FAIL sat_stall_cnt16: got %0d expected 20", obs_stall(0)); end
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(0, 49) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      imem_ready   = ($urandom_range(0, 3) != 0);
      ex_mem_read  = ($urandom_range(0, 1) == 1);
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rs   = ($urandom_range(0, 1) == 1);
      id_uses_rt   = ($urandom_range(0, 1) == 1);
      #1;
      for (int i = 0; i < 3; i++) begin
        checks += 4;
        if (obs_ctl(i) !== exp_ctl(mdl[i])) begin errors++; $display("FAIL rnd_ctl dut%0d step%0d: got %b expected %b", i, n, obs_ctl(i), exp_ctl(mdl[i])); end
        if (obs_state(i) !== exp_state(mdl[i])) begin errors++; $display("FAIL rnd_state dut%0d step%0d: got %0d expected %0d", i, n, obs_state(i), exp_state(mdl[i])); end
        if (obs_stall(i) !== mdl[i].stall) begin errors++; $display("FAIL rnd_stall dut%0d step%0d: got %0d expected %0d", i, n, obs_stall(i), mdl[i].stall); end
        if (obs_flush(i) !== mdl[i].flush) begin errors++; $display("FAIL rnd_flush dut%0d step%0d: got %0d expected %0d", i, n, obs_flush(i), mdl[i].flush); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_load_use_ll1();
    test_load_use_ll3();
    test_branch();
    test_imem_wait();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
